// File: rtl/ab_burst_gen.sv
// Stimulus burst generator for the !a |=> b and x |=> y checkers.
// Latency: beats start the cycle after start is taken; done lands len+GAP+2 cycles after start.
// Backpressure: none; start is only honoured while idle, otherwise dropped.
module ab_burst_gen #(
    parameter int LEN_W = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             inject_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             x_o,
    output logic             y_o,
    output logic [CNT_W-1:0] burst_cnt_o
);

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_TAIL,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] beat_q;
    logic [GW-1:0]    gap_q;
    logic             busy_q;
    logic             done_q;
    logic             a_q;
    logic             b_q;
    logic             c_q;
    logic             x_q;
    logic             y_q;
    logic [CNT_W-1:0] burst_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_q         <= 1'b1;
            b_q         <= 1'b0;
            c_q         <= 1'b0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            y_q    <= x_q;
            // a is low only in ACTIVE, so gating on state keeps injection confined to beats
            b_q    <= !a_q && !(inject_err_i && (state_q == ST_ACTIVE));
            case (state_q)
                ST_IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        state_q <= ST_ACTIVE;
                        beat_q  <= len_i;
                        busy_q  <= 1'b1;
                        a_q     <= 1'b0;
                        x_q     <= 1'b1;
                        c_q     <= (len_i == LEN_W'(1));
                    end
                end
                ST_ACTIVE: begin
                    beat_q <= beat_q - LEN_W'(1);
                    x_q    <= 1'b0;
                    if (beat_q == LEN_W'(1)) begin
                        state_q <= ST_TAIL;
                        a_q     <= 1'b1;
                        c_q     <= 1'b0;
                    end else begin
                        c_q <= (beat_q == LEN_W'(2));
                    end
                end
                ST_TAIL: begin
                    if (GAP == 0) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end else begin
                        state_q <= ST_GAP;
                        gap_q   <= GW'(GAP);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(1)) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign c_o         = c_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_ab_burst_gen.sv
// Randomised and directed bench for ab_burst_gen against a burst-timing reference model.
module tb_ab_burst_gen;
    localparam int LEN_W = 4;
    localparam int GAP   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             inject_err = 1'b0;
    logic             busy_o, done_o, a_o, b_o, c_o, x_o, y_o;
    logic [CNT_W-1:0] burst_cnt_o;

    ab_burst_gen #(.LEN_W(LEN_W), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len),
        .inject_err_i(inject_err), .busy_o(busy_o), .done_o(done_o),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .x_o(x_o), .y_o(y_o),
        .burst_cnt_o(burst_cnt_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int t = 0;
    // reference model: a burst is described by the cycle its start was presented and its length
    bit             m_have = 1'b0;
    int             m_s = 0;
    int             m_len = 0;
    logic           m_busy = 1'b0;
    logic           prev_a = 1'b1;
    logic           prev_x = 1'b0;
    logic           prev_inj = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    // observations of the DUT
    logic           dut_prev_a = 1'b1;
    int             viol = 0;
    int             dones = 0;
    int             wrap_seen = 0;
    int             tr_s = -100;
    logic [15:0]    tr_a, tr_b, tr_c, tr_x, tr_y, tr_busy, tr_done;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0; m_busy = 1'b0; m_cnt = '0;
        prev_a = 1'b1; prev_x = 1'b0; prev_inj = 1'b0;
        dut_prev_a = 1'b1;
    endtask

    task automatic check_cycle();
        int k;
        int kt;
        logic ea, eb, ec, ex, ey, ebusy, edone;
        k = t - m_s;
        ea = 1'b1; ec = 1'b0; ex = 1'b0; ebusy = 1'b0; edone = 1'b0;
        if (m_have) begin
            ea    = !(k >= 1 && k <= m_len);
            ec    = (k == m_len);
            ex    = (k == 1);
            ebusy = (k >= 1 && k <= m_len + GAP + 1);
            edone = (k == m_len + GAP + 2);
        end
        eb = !prev_a && !prev_inj;
        ey = prev_x;
        if (edone) m_cnt = m_cnt + 1'b1;
        cmp("a", a_o, ea);
        cmp("b", b_o, eb);
        cmp("c", c_o, ec);
        cmp("x", x_o, ex);
        cmp("y", y_o, ey);
        cmp("busy", busy_o, ebusy);
        cmp("done", done_o, edone);
        cmp("burst_cnt", burst_cnt_o, m_cnt);
        if (!dut_prev_a && !b_o) viol++;
        dut_prev_a = a_o;
        if (done_o) begin
            dones++;
            if (burst_cnt_o == '0) wrap_seen++;
        end
        kt = t - tr_s;
        if (kt >= 0 && kt < 16) begin
            tr_a[kt] = a_o; tr_b[kt] = b_o; tr_c[kt] = c_o; tr_x[kt] = x_o;
            tr_y[kt] = y_o; tr_busy[kt] = busy_o; tr_done[kt] = done_o;
        end
        prev_a = ea;
        prev_x = ex;
        m_busy = ebusy;
    endtask

    task automatic step(input logic st, input int ln, input logic inj);
        logic [LEN_W-1:0] lv;
        check_cycle();
        lv = ln[LEN_W-1:0];
        start = st; len = lv; inject_err = inj;
        prev_inj = inj && !prev_a;
        if (!m_busy && st && (lv != '0)) begin
            m_have = 1'b1; m_s = t; m_len = int'(lv);
        end
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        int d0, v0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_a", a_o, 1'b1);
        cmp("rst_busy", busy_o, 1'b0);
        cmp("rst_cnt", burst_cnt_o, 0);
        rst_n = 1'b1;
        model_reset();

        // len=3 from reset, literal timeline
        tr_s = t; step(1'b1, 3, 1'b0); idle(16);
        cmp("len3_a", tr_a, 16'hFFF1);
        cmp("len3_b", tr_b, 16'h001C);
        cmp("len3_c", tr_c, 16'h0008);
        cmp("len3_x", tr_x, 16'h0002);
        cmp("len3_y", tr_y, 16'h0004);
        cmp("len3_busy", tr_busy, 16'h007E);
        cmp("len3_done", tr_done, 16'h0080);
        cmp("len3_cnt", burst_cnt_o, 1);

        // len=1
        tr_s = t; step(1'b1, 1, 1'b0); idle(16);
        cmp("len1_a", tr_a, 16'hFFFD);
        cmp("len1_xc", {tr_x, tr_c}, {16'h0002, 16'h0002});
        cmp("len1_b", tr_b, 16'h0004);
        cmp("len1_busy", tr_busy, 16'h001E);
        cmp("len1_done", tr_done, 16'h0020);

        // len=0 start and mid-burst start are both dropped
        d0 = dones;
        step(1'b1, 0, 1'b0); idle(3);
        step(1'b1, 5, 1'b0); idle(2);
        step(1'b1, 7, 1'b0); idle(14);
        cmp("ignored_starts_dones", dones - d0, 1);

        // error injection on the cycle-2 beat of a len=4 burst
        v0 = viol;
        tr_s = t; step(1'b1, 4, 1'b0); step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b1); idle(14);
        cmp("inj_b", tr_b, 16'h0034);
        cmp("inj_a", tr_a, 16'hFFE1);
        cmp("inj_viol", viol - v0, 1);

        // async reset in cycle 2 of a len=6 burst
        d0 = dones;
        step(1'b1, 6, 1'b0); step(1'b0, 0, 1'b0);
        check_cycle();
        #2 rst_n = 1'b0;
        #1;
        cmp("mid_rst_a", a_o, 1'b1);
        cmp("mid_rst_b", b_o, 1'b0);
        cmp("mid_rst_busy", busy_o, 1'b0);
        cmp("mid_rst_cnt", burst_cnt_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        t++;
        step(1'b1, 2, 1'b0); idle(10);
        cmp("post_rst_dones", dones - d0, 1);
        cmp("post_rst_cnt", burst_cnt_o, 1);

        // 256 back-to-back len=1 bursts, each restarted in its done cycle
        d0 = dones; v0 = viol; wrap_seen = 0;
        for (int i = 0; i < 256 * (1 + GAP + 2); i++) step(1'b1, 1, 1'b0);
        idle(8);
        cmp("b2b_dones", dones - d0, 256);
        cmp("b2b_wrap", wrap_seen, 1);
        cmp("b2b_cnt", burst_cnt_o, 1);
        cmp("b2b_viol", viol - v0, 0);

        // randomised traffic
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 3) == 0);
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
